// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two requester ports, the data-memory port and status
// signals shared by the arbiter (slave) and its environment (master).
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_err;

    logic              DM_enable;
    logic              DM_read;
    logic              DM_write;
    logic [ADDR_W-1:0] DM_address;
    logic [DATA_W-1:0] DM_in;
    logic [DATA_W-1:0] DM_out;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_err,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata, ext_err,
        output DM_enable, DM_read, DM_write, DM_address, DM_in,
        input  DM_out,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata, ext_err,
        input  DM_enable, DM_read, DM_write, DM_address, DM_in,
        output DM_out,
        input  busy, owner
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data-memory port between
// the CPU and an external master; fixed 3-cycle req/ack accesses.
module dm_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    dm_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              dm_en_q, dm_en_d;
    logic              dm_rd_q, dm_rd_d;
    logic              dm_wr_q, dm_wr_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_in_q, dm_in_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              ext_ack_q, ext_ack_d;
    logic              ext_err_q, ext_err_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic              pick_ext;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dm_en_d      = 1'b0;
        dm_rd_d      = 1'b0;
        dm_wr_d      = 1'b0;
        dm_addr_d    = dm_addr_q;
        dm_in_d      = dm_in_q;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ext_ack_d    = 1'b0;
        ext_err_d    = 1'b0;
        ext_rdata_d  = ext_rdata_q;

        // On a tie the side that did not win last time is chosen.
        pick_ext  = (bus.cpu_req && bus.ext_req) ? ~last_grant_q : bus.ext_req;
        sel_we    = pick_ext ? bus.ext_we    : bus.cpu_we;
        sel_addr  = pick_ext ? bus.ext_addr  : bus.cpu_addr;
        sel_wdata = pick_ext ? bus.ext_wdata : bus.cpu_wdata;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.ext_req) begin
                    owner_d      = pick_ext;
                    last_grant_d = pick_ext;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    if (sel_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        // Strobes are registered so they are high exactly in ACCESS.
                        err_d     = 1'b0;
                        state_d   = ACCESS;
                        dm_en_d   = 1'b1;
                        dm_rd_d   = ~sel_we;
                        dm_wr_d   = sel_we;
                        dm_addr_d = sel_addr;
                        dm_in_d   = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // DM_out is valid now; ack and rdata register together on exit.
                state_d = IDLE;
                if (owner_q) begin
                    ext_ack_d = 1'b1;
                    ext_err_d = err_q;
                    if (!we_q && !err_q) ext_rdata_d = bus.DM_out;
                end else begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = err_q;
                    if (!we_q && !err_q) cpu_rdata_d = bus.DM_out;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dm_en_q      <= 1'b0;
            dm_rd_q      <= 1'b0;
            dm_wr_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_in_q      <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_ack_q    <= 1'b0;
            ext_err_q    <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dm_en_q      <= dm_en_d;
            dm_rd_q      <= dm_rd_d;
            dm_wr_q      <= dm_wr_d;
            dm_addr_q    <= dm_addr_d;
            dm_in_q      <= dm_in_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_ack_q    <= ext_ack_d;
            ext_err_q    <= ext_err_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ext_ack    = ext_ack_q;
    assign bus.ext_err    = ext_err_q;
    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.DM_enable  = dm_en_q;
    assign bus.DM_read    = dm_rd_q;
    assign bus.DM_write   = dm_wr_q;
    assign bus.DM_address = dm_addr_q;
    assign bus.DM_in      = dm_in_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.owner      = owner_q;
endmodule
